popcount_cell_sequencer: RTL

//  Counts the ones in a DATA_W-bit word using the external 3-input

---
 rtl/popcount_cell_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/popcount_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : popcount_cell_sequencer
// Description : Counts the ones in a DATA_W-bit word by feeding it, three
//               bits at a time, to a shared external 3-input ones-counter
//               cell. Each group is held for SETTLE_CYC clocks, the cell's
//               2-bit result is sampled and accumulated, and each result is
//               cross-checked against a locally computed count.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_cell_sequencer #(
    parameter int DATA_W     = 12,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              cell_a,
    output logic              cell_b,
    output logic              cell_c,
    input  logic              cell_y1,
    input  logic              cell_y0,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              mismatch
);

    // Number of 3-bit groups and the zero-padded word width that covers them
    localparam int c_NUM_GRP = (DATA_W + 2) / 3;
    localparam int c_PAD_W   = 3 * c_NUM_GRP;
    localparam int c_GRP_W   = (c_NUM_GRP > 1) ? $clog2(c_NUM_GRP) : 1;
    localparam int c_TMR_W   = $clog2(SETTLE_CYC + 1);

    localparam logic [c_GRP_W-1:0] c_LAST_GRP = c_GRP_W'(c_NUM_GRP - 1);
    localparam logic [c_GRP_W-1:0] c_GRP_ONE  = c_GRP_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD = c_TMR_W'(SETTLE_CYC);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_WAIT = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [c_PAD_W-1:0] r_word;    // groups not yet driven, next group in [2:0]
    logic [c_GRP_W-1:0] r_grp;     // index of the group currently on the cell
    logic [c_TMR_W-1:0] r_tmr;
    logic [CNT_W-1:0]   r_acc;

    logic [c_PAD_W-1:0] w_pad;
    logic [1:0]         w_sample;
    logic [1:0]         w_ref;
    logic [CNT_W-1:0]   w_sum;

    // Bits beyond DATA_W in the last group are driven as zeros
    generate
        if (c_PAD_W > DATA_W) begin : g_pad
            assign w_pad = {{(c_PAD_W - DATA_W){1'b0}}, data_in};
        end else begin : g_nopad
            assign w_pad = data_in;
        end
    endgenerate

    // Cell result, local reference for the triple being driven, and new total
    assign w_sample = {cell_y1, cell_y0};
    assign w_ref    = {1'b0, cell_a} + {1'b0, cell_b} + {1'b0, cell_c};
    assign w_sum    = r_acc + CNT_W'(w_sample);

    // Sequencer: accept a word, step through groups, accumulate, report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_S_IDLE;
            r_word   <= '0;
            r_grp    <= '0;
            r_tmr    <= '0;
            r_acc    <= '0;
            cell_a   <= 1'b0;
            cell_b   <= 1'b0;
            cell_c   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            mismatch <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Group 0 goes straight onto the cell; the rest wait in r_word
                        cell_a   <= w_pad[0];
                        cell_b   <= w_pad[1];
                        cell_c   <= w_pad[2];
                        r_word   <= w_pad >> 3;
                        r_grp    <= '0;
                        r_tmr    <= c_TMR_LOAD;
                        r_acc    <= '0;
                        mismatch <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= c_S_WAIT;
                    end else begin
                        r_state <= c_S_IDLE;
                    end
                end

                c_S_WAIT: begin
                    if (r_tmr == c_TMR_ONE) begin
                        r_acc <= w_sum;
                        if (w_sample != w_ref) begin
                            mismatch <= 1'b1;
                        end
                        if (r_grp != c_LAST_GRP) begin
                            cell_a <= r_word[0];
                            cell_b <= r_word[1];
                            cell_c <= r_word[2];
                            r_word <= r_word >> 3;
                            r_grp  <= r_grp + c_GRP_ONE;
                            r_tmr  <= c_TMR_LOAD;
                        end else begin
                            count   <= w_sum;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= c_S_DONE;
                        end
                    end else begin
                        r_tmr <= r_tmr - c_TMR_ONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
